dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the single-port, word-wide DataMemory (async read, write on clk when writeEnable).
//  Shares it between two requesters: port 0 = core load/store unit, port 1 = program loader/debug.
//  Adds byte/half/word access: sub-word loads are extracted and extended; sub-word stores use read-modify-write.
//  Rejects misaligned and out-of-range accesses with an error flag; no memory write occurs on a rejected access.
// PARAMETERS
//  MEM_WORDS  64  number of 32-bit words in DataMemory; legal word index is addr[31:2] < MEM_WORDS
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  req0/req1  in   1   request; held stable with its fields until gnt
//  we0/we1    in   1   1 = store, 0 = load
//  size0/size1 in  2   00 byte, 01 half, 10 word, 11 illegal
//  uns0/uns1  in   1   load zero-extend (1) / sign-extend (0)
//  addr0/addr1 in  32  byte address
//  wdata0/wdata1 in 32 store data, valid in low bits for sub-word stores
//  gnt0/gnt1  out  1   one-cycle completion pulse to the served port
//  rdata      out  32  load result, valid in gnt cycle (0 for stores)
//  err        out  1   access rejected, valid in gnt cycle
//  busy       out  1   FSM not in IDLE
//  mem_addr   out  32  to DataMemory address: word-aligned {addr[31:2],2'b00}
//  mem_wdata  out  32  to DataMemory writeData
//  mem_we     out  1   to DataMemory writeEnable
//  mem_rdata  in   32  from DataMemory readData (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, gnt0/gnt1=0, rdata=0, err=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_last=1.
//  mem_we = (state==WR) & ~rst: no memory write at an edge where rst=1, even mid-operation.
//  States: IDLE, RD, WR, RESP.
//  IDLE: sample req0/req1; none -> stay. One -> grant it. Both -> round-robin: grant port != rr_last, update rr_last.
//   Latch we/size/uns/addr/wdata of winner. Check: size==11, half with addr[0]=1, word with addr[1:0]!=0,
//   or addr[31:2]>=MEM_WORDS -> err_q=1, go RESP. Else load -> RD; word store -> WR; sub-word store -> RD.
//  RD: mem_addr driven; capture mem_rdata into word_q. Load: rdata_q = extracted lane, extended per uns -> RESP.
//   Sub-word store: merge wdata byte/half into word_q at lane addr[1:0] (half at addr[1]) -> WR.
//  WR: mem_we=1, mem_wdata = merged word (or wdata for word store) -> RESP.
//  RESP: gnt of latched port =1 for exactly one cycle; rdata/err valid; -> IDLE.
//  Latency from IDLE sampling edge to gnt: load 2 cycles, word store 2, sub-word store 3, error 1.
//  Requester drops req on the edge where it sees gnt; req still high in next IDLE is a new request.
//  Back-to-back: at most one gnt per 2 cycles; with both requesting continuously grants alternate 0,1,0,1.
//  Byte lanes: little-endian; byte n = bits [8n+7:8n]; half at addr[1]=1 = bits [31:16].
//  Ports' req/fields ignored outside IDLE; changing them mid-access is a protocol violation (no effect).
// STRUCTURE
//  Package dmem_ctrl_pkg: size encodings (SZ_B/SZ_H/SZ_W), state encoding, MEM_WORDS default.
//  Sub-module mem_lane_align (combinational): load extract+extend and store merge given size, addr[1:0], uns.
//  Top: arbiter + FSM + latch registers; rdata/err/gnt registered, mem_* decoded from state.
// TESTING
//  Word store port0 addr 0x8 data 0x12345678, then word load addr 0x8 -> rdata 0x12345678, gnt0 2 cycles after each.
//  mem word 0x8 = 0x12345678; sb addr 0x9 data 0xAB -> word 0x1234AB78, gnt 3 cycles, mem_we high exactly 1 cycle.
//  lb addr 0x9 uns=0 on 0x1234AB78 -> rdata 0xFFFFFFAB; lhu addr 0xA -> 0x00001234.
//  Both req every cycle from reset -> grants 0,1,0,1; each gnt one-cycle pulse, never both in same cycle.
//  lw addr 0x6 / sh addr 0x3 / lw addr 4*MEM_WORDS -> err=1, gnt after 1 cycle, mem_we never asserted.
//  Assert rst during WR of sub-word store -> no memory write, all outputs at reset values next cycle, word unchanged.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes, FSM states, latched request.
// Also holds the access legality check used at request acceptance.
package dmem_ctrl_pkg;

  localparam int DMEM_WORDS = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic        port;
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  function automatic logic access_bad(input size_e size, input logic [31:0] addr,
                                      input int mem_words);
    logic bad;
    bad = (size == SZ_X)
        | ((size == SZ_H) & addr[0])
        | ((size == SZ_W) & (addr[1:0] != 2'b00))
        | ({2'b00, addr[31:2]} >= 32'(mem_words));
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extracts/extends sub-word loads and merges sub-word stores
// into the current memory word (little-endian lanes).
module mem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[7:0];
    case (off)
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      2'd3:    byte_sel = mem_word[31:24];
      default: byte_sel = mem_word[7:0];
    endcase
    half_sel = off[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    load_data = mem_word;
    case (size)
      SZ_B:    load_data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    store_word = mem_word;
    case (size)
      SZ_B: begin
        case (off)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) store_word[31:16] = wdata[15:0];
        else        store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a single-port async-read data memory.
// gnt after 2 cycles (load, word store), 3 (sub-word store, read-modify-write) or 1 (rejected).
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic        uns0,
  input  logic        uns1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  acc_t        acc_q, acc_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;

  logic        sel1;
  acc_t        cand;
  logic [31:0] load_data;
  logic [31:0] store_word;

  // On contention, serve the port that was not served last.
  always_comb begin
    sel1       = req1 & (~req0 | ~rr_last_q);
    cand.port  = sel1;
    cand.we    = sel1 ? we1 : we0;
    cand.size  = size_e'(sel1 ? size1 : size0);
    cand.uns   = sel1 ? uns1 : uns0;
    cand.addr  = sel1 ? addr1 : addr0;
    cand.wdata = sel1 ? wdata1 : wdata0;
  end

  mem_lane_align u_align (
    .size      (acc_q.size),
    .off       (acc_q.addr[1:0]),
    .uns       (acc_q.uns),
    .mem_word  (mem_rdata),
    .wdata     (acc_q.wdata),
    .load_data (load_data),
    .store_word(store_word)
  );

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    acc_d     = acc_q;
    word_d    = word_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          acc_d     = cand;
          rr_last_d = sel1;
          rdata_d   = 32'h0;
          err_d     = 1'b0;
          word_d    = cand.wdata;
          if (access_bad(cand.size, cand.addr, MEM_WORDS)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (!cand.we) begin
            state_d = ST_RD;
          end else if (cand.size == SZ_W) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (acc_q.we) begin
          word_d  = store_word;
          state_d = ST_WR;
        end else begin
          word_d  = mem_rdata;
          rdata_d = load_data;
          state_d = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    // gnt is registered so it lines up exactly with the RESP cycle.
    gnt0_d = (state_d == ST_RESP) & ~acc_d.port;
    gnt1_d = (state_d == ST_RESP) &  acc_d.port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      acc_q     <= '0;
      word_q    <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      acc_q     <= acc_d;
      word_q    <= word_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = {acc_q.addr[31:2], 2'b00};
  assign mem_wdata = word_q;
  // Gated by rst so a reset landing mid-store never commits a partial write.
  assign mem_we    = (state_q == ST_WR) & ~rst;

endmodule
